// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with terminal-count pulse.
// A load captures a start value and a reload mode. The count decrements once
// per non-paused clock in RUN. On reaching zero the block either parks in DONE
// (one-shot) or reloads and keeps running (auto-reload). Every output comes
// straight from a flop.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             pause,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             mode_reg, mode_next;
    logic             tc_reg, tc_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    // State, count, captured reload settings and registered flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            q_reg      <= ZERO;
            reload_reg <= ZERO;
            mode_reg   <= 1'b0;
            tc_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            q_reg      <= q_next;
            reload_reg <= reload_next;
            mode_reg   <= mode_next;
            tc_reg     <= tc_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    // Next-state and next-output logic. Priority is clear > load > pause > count.
    // tc defaults low so that it is a single-cycle pulse unless re-armed.
    always_comb begin
        state_next  = state_reg;
        q_next      = q_reg;
        reload_next = reload_reg;
        mode_next   = mode_reg;
        tc_next     = 1'b0;

        if (clear) begin
            // The captured reload value and mode survive a clear.
            state_next = IDLE;
            q_next     = ZERO;
        end else if (load) begin
            reload_next = load_value;
            mode_next   = auto_reload;
            q_next      = load_value;
            if (load_value != ZERO) begin
                state_next = RUN;
            end else begin
                // A zero start value is already at terminal count.
                tc_next    = 1'b1;
                state_next = auto_reload ? RUN : DONE;
            end
        end else begin
            unique case (state_reg)
                IDLE: begin
                    // Hold until a load arrives.
                end
                RUN: begin
                    if (pause) begin
                        // Count and state are frozen; tc is already defaulted low.
                    end else if (q_reg > ONE) begin
                        q_next = q_reg - ONE;
                    end else if (q_reg == ONE) begin
                        q_next  = ZERO;
                        tc_next = 1'b1;
                        if (!mode_reg) begin
                            state_next = DONE;
                        end
                    end else if (mode_reg) begin
                        // The zero cycle of auto-reload mode: restart the period.
                        q_next  = reload_reg;
                        tc_next = (reload_reg == ZERO);
                    end else begin
                        // RUN at zero in one-shot mode cannot be reached from a
                        // load. Treat it as finished so the block cannot stick.
                        state_next = DONE;
                    end
                end
                DONE: begin
                    q_next = ZERO;
                end
                default: begin
                    state_next = IDLE;
                    q_next     = ZERO;
                end
            endcase
        end

        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    assign q    = q_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign tc   = tc_reg;

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Synchronous, loadable down-counter with terminal-count detection; the counting-down counterpart of the team's 4-bit ripple up-counter. Software or a controlling FSM loads a start value; the block decrements once per enabled clock, flags terminal count, and either stops or auto-reloads. It sits beside the up-counter in the lab datapath as the programmable interval/timeout source.

## Interface

- WIDTH, 4, counter width in bits (legal 2..16)

- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces reset state immediately
- clear  input  1  synchronous clear to IDLE
- load  input  1  start/restart request, sampled on rising clk
- load_value  input  WIDTH  start value captured when load=1
- auto_reload  input  1  mode, captured together with load_value
- pause  input  1  holds count while high (RUN only)
- q  output  WIDTH  current count
- busy  output  1  high while in RUN
- done  output  1  high while in DONE
- tc  output  1  one-cycle terminal-count pulse

## Operation

- All outputs registered. Reset values: q=0, busy=0, done=0, tc=0, state=IDLE, internal reload register=0, captured mode=0.
- States: IDLE, RUN, DONE. busy=(state==RUN), done=(state==DONE).
- Priority each edge: reset > clear > load > pause > count.
- clear=1: state->IDLE, q->0, tc->0; captured reload/mode unchanged.
- load=1 (any state): reload<=load_value, mode<=auto_reload, q<=load_value, tc<=0; state->RUN if load_value!=0; if load_value==0: state->DONE, tc<=1 on that edge (mode=0), or state->RUN with tc<=1 (mode=1).
- IDLE: q holds; waits for load.
- RUN, pause=1: q, state hold; tc<=0.
- RUN, pause=0, q>1: q<=q-1, tc<=0.
- RUN, pause=0, q==1: q<=0, tc<=1; mode=0 -> state->DONE; mode=1 -> stay RUN.
- RUN, pause=0, q==0 (mode=1 only): q<=reload, tc<=(reload==0); reload==0 yields tc high every non-paused cycle.
- DONE: q holds 0, tc<=0 after its single pulse; stays until load or clear. pause ignored outside RUN.
- Arithmetic: unsigned, WIDTH bits; q never decrements below 0 (no wrap to all-ones). load_value of all-ones is legal: 2^WIDTH-1 steps.

## Timing

- Load at edge k: q=load_value and busy=1 visible after edge k.
- Non-auto, no pause, load_value=N>=1: q steps N, N-1 … 1, 0 on edges k+1..k+N; after edge k+N: q=0, tc=1, done=1, busy=0; tc low after edge k+N+1.
- Auto-reload period: N+1 non-paused cycles; tc high exactly in the cycle q==0 (first cycle only if pause held there, since tc clears while paused).
- Each pause cycle extends the count by exactly one cycle.
- Load during RUN restarts from new value on that edge; no tc for the aborted count.
- Reset mid-count: outputs return to reset values asynchronously, without waiting for clk; first load after deassertion behaves as from IDLE.
- load and clear on same edge: clear wins, state IDLE.

## Test plan

- Reset then load=1, load_value=5, auto_reload=0, WIDTH=4 -> q: 5,4,3,2,1,0; tc=1 and done=1 in cycle q first reads 0 (5 edges after load); tc=0 next cycle; q stays 0.
- Load 3 with auto_reload=1, run 12 cycles -> q: 3,2,1,0,3,2,1,0,3…; tc pulses every 4 cycles, busy stays 1, done never asserts.
- Load 4, hold pause for 3 cycles at q=2 -> q holds 2 for 3 cycles, terminal count reached 7 edges after load; single tc pulse.
- Load 9, at q=6 assert load with load_value=2 -> q becomes 2 next edge, reaches 0 two edges later, exactly one tc.
- Load 0 with auto_reload=0 -> done=1 and tc=1 immediately after load edge, busy never 1; load 15 -> 15 steps to 0, no underflow to 15.
- Load 7, assert reset asynchronously mid-cycle at q=4 -> q=0, busy=0, done=0, tc=0 before next edge; assert clear at q=3 in a second run -> IDLE, q=0, no tc.
